// File: rtl/quad_encoder_if.sv
// quad_encoder_if: two-wheel quadrature front end with sync, glitch filter,
// x4 decode into wrapping position counters and windowed velocity.
module quad_encoder_if #(
    parameter int POS_W      = 16,
    parameter int FILT_LEN   = 4,
    parameter int SAMPLE_DIV = 50000,
    parameter int VEL_W      = 12
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic                    enc_l_a,
    input  logic                    enc_l_b,
    input  logic                    enc_r_a,
    input  logic                    enc_r_b,
    input  logic                    clear,
    input  logic                    err_clr,
    output logic [2*POS_W-1:0]      encoder_export,
    output logic signed [VEL_W-1:0] vel_l,
    output logic signed [VEL_W-1:0] vel_r,
    output logic                    sample_valid,
    output logic [1:0]              err
);

    localparam int WIN_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);
    localparam logic [4:0] SU_INIT = 5'(FILT_LEN + 3);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SAMPLE_DIV - 1);
    localparam logic [POS_W-1:0] VMAX = POS_W'((1 << (VEL_W - 1)) - 1);
    localparam logic [POS_W-1:0] VMIN = ~VMAX;

    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       filt;
    logic [3:0]       fcnt [4];
    logic [4:0]       startup;
    logic             run;
    logic [1:0]       prev [2];
    logic [1:0]       dlt [2];
    logic [1:0]       up;
    logic [1:0]       dn;
    logic [1:0]       ill;
    logic [POS_W-1:0] pos [2];
    logic [POS_W-1:0] snap [2];
    logic [POS_W-1:0] pos_nxt [2];
    logic [VEL_W-1:0] vel [2];
    logic [WIN_W-1:0] win;
    logic             term;

    // Bit pairs per channel are {a,b}: left at [1:0], right at [3:2].
    assign raw  = {enc_r_a, enc_r_b, enc_l_a, enc_l_b};
    assign run  = (startup == '0);
    assign term = (win == WIN_LAST);

    assign encoder_export = {pos[1], pos[0]};
    assign vel_l = vel[0];
    assign vel_r = vel[1];

    function automatic logic [1:0] gray_bin(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    function automatic logic [VEL_W-1:0] sat(input logic [POS_W-1:0] d);
        if (!d[POS_W-1] && (d > VMAX)) return VMAX[VEL_W-1:0];
        if (d[POS_W-1] && (d < VMIN)) return VMIN[VEL_W-1:0];
        return d[VEL_W-1:0];
    endfunction

    // Filtered bits follow the synchronizer directly until startup expires.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync1   <= '0;
            sync2   <= '0;
            filt    <= '0;
            startup <= SU_INIT;
            for (int i = 0; i < 4; i++) fcnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (!run) begin
                startup <= startup - 5'd1;
                filt    <= sync2;
                for (int i = 0; i < 4; i++) fcnt[i] <= '0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (sync2[i] == filt[i]) begin
                        fcnt[i] <= '0;
                    end else if (fcnt[i] == FILT_LAST) begin
                        filt[i] <= sync2[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        up  = '0;
        dn  = '0;
        ill = '0;
        for (int c = 0; c < 2; c++) begin
            dlt[c] = gray_bin(filt[2*c +: 2]) - gray_bin(prev[c]);
            up[c]  = run && (dlt[c] == 2'd1);
            dn[c]  = run && (dlt[c] == 2'd3);
            ill[c] = run && (dlt[c] == 2'd2);
            pos_nxt[c] = pos[c] + {{(POS_W-1){dn[c]}}, up[c] | dn[c]};
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            win          <= '0;
            sample_valid <= 1'b0;
            err          <= '0;
            for (int c = 0; c < 2; c++) begin
                prev[c] <= '0;
                pos[c]  <= '0;
                snap[c] <= '0;
                vel[c]  <= '0;
            end
        end else begin
            sample_valid <= term & ~clear;
            // A fresh illegal step wins over a simultaneous err_clr.
            err <= (err & ~{2{err_clr}}) | ill;
            for (int c = 0; c < 2; c++) begin
                prev[c] <= run ? filt[2*c +: 2] : sync2[2*c +: 2];
            end
            if (clear) begin
                win <= '0;
                for (int c = 0; c < 2; c++) begin
                    pos[c]  <= '0;
                    snap[c] <= '0;
                    vel[c]  <= '0;
                end
            end else begin
                win <= term ? '0 : win + 1'b1;
                for (int c = 0; c < 2; c++) begin
                    pos[c] <= pos_nxt[c];
                    if (term) begin
                        vel[c]  <= sat(pos[c] - snap[c]);
                        snap[c] <= pos_nxt[c];
                    end
                end
            end
        end
    end

endmodule
